// File: rtl/uart_tx.sv
// Byte-wide transmit FIFO feeding an 8N1/8N2 serial transmitter.
// Divisor and stop-bit count are captured when a frame starts and held until it ends.
module uart_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  input  logic [DIV_WIDTH-1:0]          div,
  input  logic                          nstop,
  input  logic                          txen,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Handshake: a byte moves when in_valid && in_ready at a rising edge;
  // in_ready depends only on registered count, so it never reacts to a same-cycle pop.
  state_t                 state;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [7:0]             shreg;
  logic [DIV_WIDTH-1:0]   div_l;
  logic [DIV_WIDTH-1:0]   period_cnt;
  logic                   nstop_l;
  logic [2:0]             bit_cnt;
  logic                   push;
  logic                   bit_end;
  logic                   frame_end;
  logic                   start_frame;

  assign in_ready    = (count != FULL);
  assign push        = in_valid && in_ready;
  assign bit_end     = (period_cnt == '0);
  assign frame_end   = (state == STOP) && bit_end && (bit_cnt == '0);
  assign start_frame = txen && (count != '0) && ((state == IDLE) || frame_end);
  assign busy        = (state != IDLE) || (count != '0);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      txd        <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      shreg      <= '0;
      div_l      <= '0;
      nstop_l    <= 1'b0;
      period_cnt <= '0;
      bit_cnt    <= '0;
    end else begin
      if (push)        wr_ptr <= wr_ptr + 1'b1;
      if (start_frame) rd_ptr <= rd_ptr + 1'b1;
      if (push && !start_frame)      count <= count + 1'b1;
      else if (!push && start_frame) count <= count - 1'b1;

      if (start_frame) begin
        state      <= START;
        txd        <= 1'b0;
        shreg      <= mem[rd_ptr];
        div_l      <= div;
        nstop_l    <= nstop;
        period_cnt <= div;
        bit_cnt    <= '0;
      end else begin
        case (state)
          IDLE: txd <= 1'b1;
          START: begin
            if (bit_end) begin
              state      <= DATA;
              txd        <= shreg[0];
              shreg      <= {1'b0, shreg[7:1]};
              period_cnt <= div_l;
              bit_cnt    <= '0;
            end else begin
              period_cnt <= period_cnt - 1'b1;
            end
          end
          DATA: begin
            if (bit_end) begin
              period_cnt <= div_l;
              if (bit_cnt == 3'd7) begin
                // bit_cnt now counts stop bits remaining after the current one
                state   <= STOP;
                txd     <= 1'b1;
                bit_cnt <= {2'b00, nstop_l};
              end else begin
                txd     <= shreg[0];
                shreg   <= {1'b0, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              period_cnt <= period_cnt - 1'b1;
            end
          end
          STOP: begin
            if (bit_end) begin
              if (bit_cnt != '0) begin
                bit_cnt    <= bit_cnt - 1'b1;
                period_cnt <= div_l;
              end else begin
                state <= IDLE;
              end
            end else begin
              period_cnt <= period_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frame timing/FIFO/reset cases plus a random run,
// with a line monitor that decodes every frame against an expected-byte queue.
module tb_uart_tx;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [15:0] div;
  logic        nstop;
  logic        txen;
  logic        txd;
  logic        busy;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  uart_tx #(.FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .div(div), .nstop(nstop), .txen(txen),
    .txd(txd), .busy(busy), .count(count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    exp_q.push_back(b);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    txen = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 6000) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain", 32'((exp_q.size() == 0) && !busy), 32'd1);
  endtask

  // cycles from first start-bit sample to the first sample with busy low
  task automatic measure_frame(output int len);
    int n = 0;
    @(negedge clock);
    while (txd !== 1'b0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (txd !== 1'b0) begin
      check("start_timeout", 32'd0, 32'd1);
      len = -1;
      return;
    end
    len = 0;
    while (busy && len < 5000) begin
      @(negedge clock);
      len++;
    end
  endtask

  // line monitor / scoreboard: samples every cycle of a frame against the ideal waveform
  initial begin : line_monitor
    int period, nbits, errs, bi, ph;
    logic [7:0] got, e;
    logic lvl;
    bit unexpected, aborted;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1 && txd === 1'b0) begin
        period = int'(div) + 1;
        nbits  = 10 + int'(nstop);
        unexpected = (exp_q.size() == 0);
        e = unexpected ? 8'h00 : exp_q[0];
        if (unexpected) check("frame_unexpected", 32'd1, 32'd0);
        errs = 0; got = '0; aborted = 1'b0;
        for (int i = 0; i < nbits * period; i++) begin
          if (i > 0) @(negedge clock);
          if (reset === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          bi = i / period;
          ph = i % period;
          if (bi >= 1 && bi <= 8 && ph == period / 2) got[bi-1] = txd;
          lvl = (bi == 0) ? 1'b0 : (bi <= 8) ? e[bi-1] : 1'b1;
          if (txd !== lvl) errs++;
        end
        if (!aborted && !unexpected) begin
          check("frame_byte", 32'(got), 32'(e));
          check("frame_wave", 32'(errs), 32'd0);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    int len, lows;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; div = '0; nstop = 1'b0; txen = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clock); #1;

    // single byte, div=3, 8N1: 40 line cycles
    div = 16'd3; nstop = 1'b0; txen = 1'b1;
    push_byte(8'h55);
    measure_frame(len);
    check("t1_len", 32'(len), 32'd40);
    wait_drain();

    // back-to-back at div=0
    div = 16'd0;
    push_byte(8'hA5);
    push_byte(8'h3C);
    measure_frame(len);
    check("t2_len", 32'(len), 32'd20);
    wait_drain();

    // FIFO full with txen low
    txen = 1'b0; div = 16'd2;
    for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
    check("t3_ready_full", 32'(in_ready), 32'd0);
    check("t3_count_full", 32'(count), 32'd8);
    check("t3_busy_full", 32'(busy), 32'd1);
    in_data = 8'hEE; in_valid = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    check("t3_count_hold", 32'(count), 32'd8);
    in_valid = 1'b0;
    txen = 1'b1;
    @(negedge clock);
    check("t3_ready_before_pop", 32'(in_ready), 32'd0);
    @(negedge clock);
    check("t3_ready_after_pop", 32'(in_ready), 32'd1);
    check("t3_start", 32'(txd), 32'd0);
    wait_drain();
    check("t3_count_empty", 32'(count), 32'd0);

    // two stop bits, divisor changed mid-frame
    div = 16'd7; nstop = 1'b1;
    push_byte(8'hFF);
    fork
      measure_frame(len);
      begin repeat (30) @(posedge clock); #1 div = 16'd1; end
    join
    check("t4_len", 32'(len), 32'd88);
    wait_drain();

    // reset during data bit 3 with bytes queued
    txen = 1'b0; div = 16'd3; nstop = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i));
    txen = 1'b1;
    len = 0;
    @(negedge clock);
    while (txd !== 1'b0 && len < 100) begin @(negedge clock); len++; end
    repeat (17) @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(posedge clock); #1;
    check("t5_txd", 32'(txd), 32'd1);
    check("t5_count", 32'(count), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0; reset = 1'b0;
    exp_q.delete();
    @(posedge clock); #1;
    check("t5_push_ignored", 32'(count), 32'd0);
    lows = 0;
    repeat (60) begin
      @(negedge clock);
      if (txd !== 1'b1) lows++;
    end
    check("t5_quiet", 32'(lows), 32'd0);
    @(posedge clock); #1;

    // random bytes, divisors, stop bits and txen toggling
    for (int g = 0; g < 32; g++) begin
      wait_drain();
      div   = 16'($urandom_range(0, 15));
      nstop = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) begin
        txen = ($urandom_range(0, 3) != 0) || (count == 4'd8);
        push_byte(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
      end
    end
    wait_drain();
    repeat (5) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, transmit FIFO entries (power of two, >=2).
REQ-002 Parameter: DIV_WIDTH, default 16, width of the bit-period divisor.
REQ-003 Port: clock  input  1  sole clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  producer offers in_data this cycle.
REQ-006 Port: in_ready  output  1  FIFO can accept a byte this cycle.
REQ-007 Port: in_data  input  8  byte to transmit.
REQ-008 Port: div  input  DIV_WIDTH  bit period minus one, in clock cycles.
REQ-009 Port: nstop  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 Port: txen  input  1  transmit enable; gates the start of new frames.
REQ-011 Port: txd  output  1  serial line, idle high, 8N1/8N2, LSB first.
REQ-012 Port: busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-013 Port: count  output  $clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO.

Function
REQ-014 Push occurs on a rising edge with in_valid && in_ready; in_ready = (count != FIFO_DEPTH), from registered state only.
REQ-015 When full, in_ready SHALL be low even if a pop occurs in the same cycle; a byte offered while full is neither stored nor lost (the producer holds it).
REQ-016 Push and pop in the same cycle (FIFO not full) SHALL leave count unchanged; FIFO order is strict first-in first-out; pointers wrap modulo FIFO_DEPTH.
REQ-017 FSM states: IDLE, START, DATA, STOP.
REQ-018 IDLE -> START when txen==1 and count!=0.
  - On that edge: pop the head byte into the shift register.
  - Latch div and nstop for the whole frame.
  - Load the bit counter.
REQ-019 txd SHALL be a registered output; it goes low on the edge that enters START, so the first start-bit cycle is 1 clock after the IDLE decision.
REQ-020 Each bit (start, each data bit, each stop bit) SHALL hold txd for exactly latched_div+1 clock cycles, via a down-counter reloaded at every bit boundary.
REQ-021 START -> DATA after one bit period; DATA shifts out bit0..bit7 (LSB first), then -> STOP.
REQ-022 STOP drives txd=1 for one bit period (nstop==0) or two bit periods (nstop==1).
REQ-023 At the end of STOP:
  - If txen==1 and count!=0, go directly to START (back-to-back frames, no extra idle cycle).
  - Otherwise go to IDLE.
REQ-024 div changes or nstop changes mid-frame SHALL NOT affect the frame in progress.
REQ-025 div==0 SHALL give one clock per bit; div = all-ones SHALL give 2^DIV_WIDTH clocks per bit with no counter overflow.
REQ-026 txen deasserted mid-frame: the current frame SHALL complete including stop bit(s); no new frame starts while txen==0; FIFO contents are retained.
REQ-027 busy = (state != IDLE) || (count != 0), registered-state derived.
REQ-028 Line frame time = (10 + nstop) * (div+1) clocks.

Reset
REQ-029 While reset is high on a rising edge, the block SHALL set:
  - state = IDLE
  - txd = 1
  - FIFO pointers and count = 0
  - in_ready = 1
  - busy = 0
  - bit and period counters = 0
REQ-030 Reset asserted mid-frame SHALL abort the frame: txd = 1 from the next edge, buffered bytes are discarded, and no partial frame resumes after reset deasserts.
REQ-031 A push presented in the same cycle as reset SHALL be ignored.

Verification
REQ-032 Single byte: div=3, nstop=0, txen=1, push 0x55.
  - txd low 4 cycles, then 0,1,0,1,0,1,0,1... wait, LSB first: 1,0,1,0,1,0,1,0, each 4 cycles, then 1 for 4 cycles.
  - Then IDLE; busy drops after 40 line cycles.
REQ-033 Back-to-back: div=0, push 0xA5 and 0x3C consecutively.
  - Frame 2's start bit immediately follows frame 1's stop bit, 20 cycles total.
  - Decoded bytes are 0xA5, 0x3C.
REQ-034 FIFO full: txen=0, push 9 bytes with FIFO_DEPTH=8.
  - in_ready falls after the 8th byte; count=8.
  - After raising txen, exactly bytes 1-8 are sent in order; in_ready rises one cycle after the first pop.
REQ-035 Two stop bits and divisor latch: nstop=1, div=7, push 0xFF, change div to 1 during DATA.
  - Frame lasts 11*8=88 cycles, with the stop level held 16 cycles.
REQ-036 Reset mid-frame: assert reset during data bit 3 with 3 bytes queued.
  - Next edge: txd=1, count=0, busy=0.
  - After release with txen=1, no transmission occurs.
REQ-037 Reference-model check: a bench line monitor samples txd at mid-bit and compares against 256 random bytes with random div (0..15) and nstop, including random txen toggling. It SHALL show zero mismatches and zero framing errors.
